// File: rtl/time_keeper_pkg.sv
// Shared types, limits and BCD helpers for the time-of-day counter.
package time_keeper_pkg;

    typedef logic [3:0] bcd_t;

    localparam int unsigned SEC_MAX   = 59;
    localparam int unsigned MIN_MAX   = 59;
    localparam int unsigned HR_MAX    = 23;
    localparam int unsigned ALARM_LEN = 60;

    typedef struct packed {
        logic pm;
        bcd_t tens;
        bcd_t units;
    } disp_hour_t;

    function automatic logic [7:0] to_bcd(input int unsigned v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] bcd_up(input logic [7:0] v, input logic [7:0] max);
        if (v == max) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_down(input logic [7:0] v, input logic [7:0] max);
        if (v == 8'h00) return max;
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    // 00 -> 12 AM, 01..11 AM, 12 -> 12 PM, 13..23 -> 01..11 PM
    function automatic disp_hour_t to_12h(input bcd_t tens, input bcd_t units);
        int unsigned h;
        logic [7:0]  b;
        disp_hour_t  r;
        h = 32'(tens) * 10 + 32'(units);
        if (h == 0) begin
            r.pm = 1'b0;
            b    = 8'h12;
        end else if (h < 12) begin
            r.pm = 1'b0;
            b    = to_bcd(h);
        end else if (h == 12) begin
            r.pm = 1'b1;
            b    = 8'h12;
        end else begin
            r.pm = 1'b1;
            b    = to_bcd(h - 12);
        end
        r.tens  = b[7:4];
        r.units = b[3:0];
        return r;
    endfunction

endpackage

// File: rtl/time_keeper_if.sv
// Adjust inputs and display outputs of time_keeper; ALARM_EN adds the alarm signals.
interface time_keeper_if import time_keeper_pkg::*; ();

    logic hour_inc;
    logic hour_dec;
    logic min_inc;
    logic min_dec;
    logic sec_clear;
    logic mode_tgl;
    bcd_t seconds;
    bcd_t t_secs;
    bcd_t minutes;
    bcd_t t_mins;
    bcd_t hours;
    bcd_t t_hours;
    logic pm;
    logic sec_tick;
`ifdef ALARM_EN
    logic alarm_sel;
    logic alarm_arm;
    logic alarm_clr;
    logic alarm_hit;
`endif

    modport master (
        output hour_inc, hour_dec, min_inc, min_dec, sec_clear, mode_tgl,
        input  seconds, t_secs, minutes, t_mins, hours, t_hours, pm, sec_tick
`ifdef ALARM_EN
        , output alarm_sel, alarm_arm, alarm_clr
        , input  alarm_hit
`endif
    );

    modport slave (
        input  hour_inc, hour_dec, min_inc, min_dec, sec_clear, mode_tgl,
        output seconds, t_secs, minutes, t_mins, hours, t_hours, pm, sec_tick
`ifdef ALARM_EN
        , input  alarm_sel, alarm_arm, alarm_clr
        , output alarm_hit
`endif
    );

endinterface

// File: rtl/time_keeper_bcd_wrap_counter.sv
// Two-digit BCD wrap counter: chain tick first (carry out), then one adjust step.
module time_keeper_bcd_wrap_counter import time_keeper_pkg::*; #(
    parameter int unsigned MAX = 59
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_inc,
    input  logic i_dec,
    input  logic i_clr,
    output bcd_t o_tens,
    output bcd_t o_units,
    output logic o_carry,
    output logic o_borrow
);

    localparam logic [7:0] MAX_BCD = to_bcd(MAX);

    logic [7:0] r_val;
    logic [7:0] w_ticked;
    logic [7:0] w_next;

    // Adjust applies to the already-ticked value so tick carries are never lost.
    always_comb begin
        w_ticked = i_tick ? bcd_up(r_val, MAX_BCD) : r_val;
        w_next   = w_ticked;
        if (i_clr) begin
            w_next = 8'h00;
        end else if (i_inc) begin
            w_next = bcd_up(w_ticked, MAX_BCD);
        end else if (i_dec) begin
            w_next = bcd_down(w_ticked, MAX_BCD);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_val <= 8'h00;
        end else begin
            r_val <= w_next;
        end
    end

    assign o_carry  = i_tick && (r_val == MAX_BCD);
    assign o_borrow = !i_clr && !i_inc && i_dec && (w_ticked == 8'h00);
    assign o_tens   = r_val[7:4];
    assign o_units  = r_val[3:0];

endmodule

// File: rtl/time_keeper.sv
// BCD HH:MM:SS time-of-day counter with 1 Hz prescaler, adjust pulses and 12/24 h display.
// Optional alarm (alarm HH:MM registers, alarm_hit) is built when ALARM_EN is defined.
module time_keeper import time_keeper_pkg::*; #(
    parameter int unsigned CLK_HZ  = 12_000_000,
    parameter bit          DEF_24H = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    time_keeper_if.slave         io_bus
);

    localparam int unsigned     PW         = $clog2(CLK_HZ);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_HZ - 1);

    logic [PW-1:0] r_presc;
    logic          r_sec_tick;
    logic          r_mode_24;
    logic          w_tick;
    logic          w_sel;
    logic          w_hr_inc, w_hr_dec, w_mn_inc, w_mn_dec;
    logic          w_sec_carry, w_min_carry;
    bcd_t          w_sec_t, w_sec_u, w_min_t, w_min_u, w_hr_t, w_hr_u;
    disp_hour_t    w_h12;
    logic          w_unused_hr_carry, w_unused_sec_b, w_unused_min_b, w_unused_hr_b;

    // sec_clear restarts the second, so it also suppresses a coincident tick.
    assign w_tick = (r_presc == PRESC_LAST) && !io_bus.sec_clear;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc    <= '0;
            r_sec_tick <= 1'b0;
            r_mode_24  <= DEF_24H;
        end else begin
            r_presc    <= (io_bus.sec_clear || r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
            r_sec_tick <= w_tick;
            r_mode_24  <= r_mode_24 ^ io_bus.mode_tgl;
        end
    end

`ifdef ALARM_EN
    assign w_sel = io_bus.alarm_sel;
`else
    assign w_sel = 1'b0;
`endif

    // One adjust per cycle: hour_inc > hour_dec > min_inc > min_dec.
    assign w_hr_inc = io_bus.hour_inc;
    assign w_hr_dec = !io_bus.hour_inc && io_bus.hour_dec;
    assign w_mn_inc = !io_bus.hour_inc && !io_bus.hour_dec && io_bus.min_inc;
    assign w_mn_dec = !io_bus.hour_inc && !io_bus.hour_dec && !io_bus.min_inc && io_bus.min_dec;

    time_keeper_bcd_wrap_counter #(.MAX(SEC_MAX)) u_sec (
        .clk      (clk),
        .rst      (rst),
        .i_tick   (w_tick),
        .i_inc    (1'b0),
        .i_dec    (1'b0),
        .i_clr    (io_bus.sec_clear),
        .o_tens   (w_sec_t),
        .o_units  (w_sec_u),
        .o_carry  (w_sec_carry),
        .o_borrow (w_unused_sec_b)
    );

    time_keeper_bcd_wrap_counter #(.MAX(MIN_MAX)) u_min (
        .clk      (clk),
        .rst      (rst),
        .i_tick   (w_sec_carry),
        .i_inc    (w_mn_inc && !w_sel),
        .i_dec    (w_mn_dec && !w_sel),
        .i_clr    (1'b0),
        .o_tens   (w_min_t),
        .o_units  (w_min_u),
        .o_carry  (w_min_carry),
        .o_borrow (w_unused_min_b)
    );

    time_keeper_bcd_wrap_counter #(.MAX(HR_MAX)) u_hr (
        .clk      (clk),
        .rst      (rst),
        .i_tick   (w_min_carry),
        .i_inc    (w_hr_inc && !w_sel),
        .i_dec    (w_hr_dec && !w_sel),
        .i_clr    (1'b0),
        .o_tens   (w_hr_t),
        .o_units  (w_hr_u),
        .o_carry  (w_unused_hr_carry),
        .o_borrow (w_unused_hr_b)
    );

    always_comb begin
        w_h12 = to_12h(w_hr_t, w_hr_u);
    end

    assign io_bus.seconds  = w_sec_u;
    assign io_bus.t_secs   = w_sec_t;
    assign io_bus.minutes  = w_min_u;
    assign io_bus.t_mins   = w_min_t;
    assign io_bus.hours    = r_mode_24 ? w_hr_u : w_h12.units;
    assign io_bus.t_hours  = r_mode_24 ? w_hr_t : w_h12.tens;
    assign io_bus.pm       = !r_mode_24 && w_h12.pm;
    assign io_bus.sec_tick = r_sec_tick;

`ifdef ALARM_EN
    bcd_t       w_al_mn_t, w_al_mn_u, w_al_hr_t, w_al_hr_u;
    logic       w_unused_al_mc, w_unused_al_mb, w_unused_al_hc, w_unused_al_hb;
    logic       w_match;
    logic       r_alarm_hit;
    logic [5:0] r_alarm_cnt;

    time_keeper_bcd_wrap_counter #(.MAX(MIN_MAX)) u_al_min (
        .clk      (clk),
        .rst      (rst),
        .i_tick   (1'b0),
        .i_inc    (w_mn_inc && w_sel),
        .i_dec    (w_mn_dec && w_sel),
        .i_clr    (1'b0),
        .o_tens   (w_al_mn_t),
        .o_units  (w_al_mn_u),
        .o_carry  (w_unused_al_mc),
        .o_borrow (w_unused_al_mb)
    );

    time_keeper_bcd_wrap_counter #(.MAX(HR_MAX)) u_al_hr (
        .clk      (clk),
        .rst      (rst),
        .i_tick   (1'b0),
        .i_inc    (w_hr_inc && w_sel),
        .i_dec    (w_hr_dec && w_sel),
        .i_clr    (1'b0),
        .o_tens   (w_al_hr_t),
        .o_units  (w_al_hr_u),
        .o_carry  (w_unused_al_hc),
        .o_borrow (w_unused_al_hb)
    );

    assign w_match = ({w_hr_t, w_hr_u, w_min_t, w_min_u} == {w_al_hr_t, w_al_hr_u,
                      w_al_mn_t, w_al_mn_u}) && ({w_sec_t, w_sec_u} == 8'h00);

    // Evaluated in the cycle the freshly ticked time is visible.
    always_ff @(posedge clk) begin
        if (rst || io_bus.alarm_clr || !io_bus.alarm_arm) begin
            r_alarm_hit <= 1'b0;
            r_alarm_cnt <= '0;
        end else if (r_sec_tick && w_match) begin
            r_alarm_hit <= 1'b1;
            r_alarm_cnt <= '0;
        end else if (r_alarm_hit && r_sec_tick) begin
            if (r_alarm_cnt == 6'(ALARM_LEN - 1)) begin
                r_alarm_hit <= 1'b0;
            end
            r_alarm_cnt <= r_alarm_cnt + 6'd1;
        end
    end

    assign io_bus.alarm_hit = r_alarm_hit;
`endif

endmodule

// File: tb/tb_time_keeper.sv
// Directed table-driven bench for time_keeper at CLK_HZ=10 (default build, 24 h reset mode).
module tb_time_keeper;

    typedef struct {
        logic [5:0]  ctl;   // {hour_inc, hour_dec, min_inc, min_dec, sec_clear, mode_tgl}
        int          n;
        logic [23:0] disp;
        logic        pm;
    } vec_t;

    logic        clk;
    logic        rst;
    int          checks;
    int          errors;
    int          tick_cnt;
    vec_t        vecs [20];
    logic [23:0] w_disp;

    time_keeper_if u_if ();

    time_keeper #(
        .CLK_HZ  (10),
        .DEF_24H (1'b1)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (u_if)
    );

    assign w_disp = {u_if.t_hours, u_if.hours, u_if.t_mins, u_if.minutes, u_if.t_secs,
                     u_if.seconds};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [5:0] ctl, input int n, input logic [23:0] d,
                                input logic p);
        vec_t v;
        v.ctl  = ctl;
        v.n    = n;
        v.disp = d;
        v.pm   = p;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (u_if.sec_tick) tick_cnt++;
        end
    endtask

    task automatic set_ctl(input logic [5:0] ctl);
        {u_if.hour_inc, u_if.hour_dec, u_if.min_inc, u_if.min_dec, u_if.sec_clear,
         u_if.mode_tgl} = ctl;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        tick_cnt = 0;
        set_ctl(6'b0);
`ifdef ALARM_EN
        u_if.alarm_sel = 1'b0;
        u_if.alarm_arm = 1'b0;
        u_if.alarm_clr = 1'b0;
`endif
        vecs[0]  = mk(6'b000010,  1, 24'h000000, 1'b0);
        vecs[1]  = mk(6'b000110,  1, 24'h005900, 1'b0);
        vecs[2]  = mk(6'b010010,  1, 24'h235900, 1'b0);
        vecs[3]  = mk(6'b101010,  1, 24'h005900, 1'b0);
        vecs[4]  = mk(6'b001010,  1, 24'h000000, 1'b0);
        vecs[5]  = mk(6'b001010, 15, 24'h001500, 1'b0);
        vecs[6]  = mk(6'b000011,  1, 24'h121500, 1'b0);
        vecs[7]  = mk(6'b100010, 13, 24'h011500, 1'b1);
        vecs[8]  = mk(6'b000110, 10, 24'h010500, 1'b1);
        vecs[9]  = mk(6'b000011,  1, 24'h130500, 1'b0);
        vecs[10] = mk(6'b000011,  1, 24'h010500, 1'b1);
        vecs[11] = mk(6'b010010,  1, 24'h120500, 1'b1);
        vecs[12] = mk(6'b010010,  1, 24'h110500, 1'b0);
        vecs[13] = mk(6'b010010, 11, 24'h120500, 1'b0);
        vecs[14] = mk(6'b010010,  1, 24'h110500, 1'b1);
        vecs[15] = mk(6'b000011,  1, 24'h230500, 1'b0);
        vecs[16] = mk(6'b010110,  1, 24'h220500, 1'b0);
        vecs[17] = mk(6'b000110,  1, 24'h220400, 1'b0);
        vecs[18] = mk(6'b100010,  1, 24'h230400, 1'b0);
        vecs[19] = mk(6'b001010, 55, 24'h235900, 1'b0);

        // Reset and first tick
        rst = 1'b1;
        step(2);
        check("reset_disp", 32'(w_disp), 32'h000000);
        check("reset_pm", 32'(u_if.pm), 32'd0);
        check("reset_tick", 32'(u_if.sec_tick), 32'd0);
        rst = 1'b0;
        step(9);
        check("pre_tick", 32'({u_if.sec_tick, u_if.seconds}), 32'h00);
        step(1);
        check("first_tick", 32'(u_if.sec_tick), 32'd1);
        check("first_sec", 32'(w_disp), 32'h000001);
        step(1);
        check("tick_pulse_end", 32'(u_if.sec_tick), 32'd0);

        // Adjust and display-mode vectors; sec_clear in each row keeps the prescaler at 0
        for (int i = 0; i < 20; i++) begin
            set_ctl(vecs[i].ctl);
            step(vecs[i].n);
            set_ctl(6'b0);
            check($sformatf("vec%0d_disp", i), 32'(w_disp), 32'(vecs[i].disp));
            check($sformatf("vec%0d_pm", i), 32'(u_if.pm), 32'(vecs[i].pm));
        end

        // 23:59:59 rolls over to 00:00:00
        step(590);
        check("day_pre_roll", 32'(w_disp), 32'h235959);
        tick_cnt = 0;
        step(10);
        check("day_roll", 32'(w_disp), 32'h000000);
        check("day_roll_ticks", 32'(tick_cnt), 32'd1);
        check("day_roll_pulse", 32'(u_if.sec_tick), 32'd1);

        // Tick carry plus min_inc in the same cycle
        set_ctl(6'b100010);
        step(10);
        set_ctl(6'b000110);
        step(1);
        set_ctl(6'b0);
        check("set_1059", 32'(w_disp), 32'h105900);
        step(590);
        check("at_105959", 32'(w_disp), 32'h105959);
        step(9);
        u_if.min_inc = 1'b1;
        step(1);
        u_if.min_inc = 1'b0;
        check("tick_plus_min_inc", 32'(w_disp), 32'h110100);
        check("tick_plus_min_pulse", 32'(u_if.sec_tick), 32'd1);

        // sec_clear mid-second restarts the prescaler
        step(14);
        check("mid_second", 32'(w_disp), 32'h110101);
        u_if.sec_clear = 1'b1;
        step(1);
        u_if.sec_clear = 1'b0;
        check("sec_clear", 32'(w_disp), 32'h110100);
        tick_cnt = 0;
        step(9);
        check("clear_no_early_tick", 32'(tick_cnt), 32'd0);
        step(1);
        check("clear_tick_after_10", 32'({u_if.sec_tick, w_disp}), 32'h1110101);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
